// File: rtl/prbs_defs_pkg.sv
// ----------------------------------------------------------------------------
// prbs_defs
// Shared definitions for the self-synchronising PRBS checker:
//   - ORDER -> (A,B) tap table for b[n] = b[n-A] ^ b[n-B]
//   - width of the per-word error count (ERRW)
//   - popcount helper
//   - lock FSM state encoding
// ----------------------------------------------------------------------------
package prbs_defs;

  typedef enum logic [1:0] {
    ST_PRIME  = 2'd0,  // waiting for the first word to fill the history
    ST_HUNT   = 2'd1,  // counting consecutive clean words
    ST_LOCKED = 2'd2   // counting consecutive errored words
  } lock_state_t;

  // Widest word the popcount helper handles.
  localparam int POPCNT_MAX = 256;

  function automatic bit order_ok(input int order);
    return (order == 7) || (order == 9) || (order == 15) ||
           (order == 23) || (order == 31);
  endfunction

  // Long tap; equal to ORDER for every supported polynomial.
  function automatic int tap_a(input int order);
    case (order)
      7:       return 7;
      9:       return 9;
      15:      return 15;
      23:      return 23;
      31:      return 31;
      default: return order;
    endcase
  endfunction

  // Short tap.
  function automatic int tap_b(input int order);
    case (order)
      7:       return 6;
      9:       return 5;
      15:      return 14;
      23:      return 18;
      31:      return 28;
      default: return 1;
    endcase
  endfunction

  // Bits needed to hold a mismatch count of 0..width.
  function automatic int errw(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int popcount(input logic [POPCNT_MAX-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < POPCNT_MAX; i++) n += int'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/prbs_predict.sv
// ----------------------------------------------------------------------------
// prbs_predict
// Combinational predictor. Every bit of the current word is predicted from
// two earlier *received* bits, so the checker needs no seed and no alignment.
// Ports:
//   history   [ORDER-1:0]      last ORDER received bits, MSB earliest
//   din       [WORDWIDTH-1:0]  current word, MSB earliest on the line
//   mismatch  [WORDWIDTH-1:0]  1 where the received bit disagrees with prediction
//   stuck                      whole window (history ++ din) is zero
// ----------------------------------------------------------------------------
module prbs_predict
  import prbs_defs::*;
#(
  parameter int WORDWIDTH = 40,
  parameter int ORDER     = 7
) (
  input  logic [ORDER-1:0]     history,
  input  logic [WORDWIDTH-1:0] din,
  output logic [WORDWIDTH-1:0] mismatch,
  output logic                 stuck
);

  localparam int A = tap_a(ORDER);
  localparam int B = tap_b(ORDER);

  // Time-ordered window: higher index = earlier bit, so "n-A" is "index+A".
  logic [ORDER+WORDWIDTH-1:0] window;
  assign window = {history, din};

  // NOTE: every variable written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    mismatch = '0;
    for (int k = 0; k < WORDWIDTH; k++)
      mismatch[k] = window[k] ^ window[k+A] ^ window[k+B];
  end

  // An all-zero window satisfies the recurrence trivially; flag it instead.
  assign stuck = (window == '0);

endmodule

// File: rtl/prbs_sync_checker.sv
// ----------------------------------------------------------------------------
// prbs_sync_checker
// Self-synchronising PRBS checker for deserialized readout words.
// Ports:
//   clk        word clock, rising edge
//   reset      synchronous, active-high
//   din        received word, din[WORDWIDTH-1] earliest on the line
//   din_valid  word qualifier; everything holds while low
//   clr_cnt    synchronous clear of err_cnt
//   error      last checked word had a mismatch or was stuck
//   err_bits   mismatch count of last checked word (WORDWIDTH when stuck)
//   locked     lock FSM is in LOCKED
//   err_cnt    saturating sum of err_bits over words checked while locked
// ----------------------------------------------------------------------------
module prbs_sync_checker
  import prbs_defs::*;
#(
  parameter  int WORDWIDTH  = 40,
  parameter  int ORDER      = 7,
  parameter  int LOCK_CNT   = 4,
  parameter  int UNLOCK_CNT = 4,
  parameter  int CNT_WIDTH  = 16,
  localparam int ERRW       = errw(WORDWIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORDWIDTH-1:0] din,
  input  logic                 din_valid,
  input  logic                 clr_cnt,
  output logic                 error,
  output logic [ERRW-1:0]      err_bits,
  output logic                 locked,
  output logic [CNT_WIDTH-1:0] err_cnt
);

  localparam int RUNMAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
  localparam int RUNW   = $clog2(RUNMAX + 1);
  localparam int SUMW   = ((CNT_WIDTH > ERRW) ? CNT_WIDTH : ERRW) + 1;

  if (!order_ok(ORDER)) begin : g_bad_order
    $error("prbs_sync_checker: unsupported ORDER %0d", ORDER);
  end
  if (WORDWIDTH < ORDER || WORDWIDTH > POPCNT_MAX) begin : g_bad_width
    $error("prbs_sync_checker: WORDWIDTH %0d out of range", WORDWIDTH);
  end

  logic [ORDER-1:0]     history;
  logic [WORDWIDTH-1:0] mismatch;
  logic                 stuck;
  logic [ERRW-1:0]      word_bits;
  logic                 word_err;

  lock_state_t          state, state_nx;
  logic [RUNW-1:0]      run_ok, run_ok_nx, run_bad, run_bad_nx;
  logic                 error_nx;
  logic [ERRW-1:0]      err_bits_nx;
  logic [CNT_WIDTH-1:0] err_cnt_nx;
  logic [SUMW-1:0]      cnt_sum;

  prbs_predict #(
    .WORDWIDTH (WORDWIDTH),
    .ORDER     (ORDER)
  ) u_predict (
    .history  (history),
    .din      (din),
    .mismatch (mismatch),
    .stuck    (stuck)
  );

  assign word_bits = stuck ? ERRW'(WORDWIDTH)
                           : ERRW'(popcount(POPCNT_MAX'(mismatch)));
  assign word_err  = (word_bits != '0);
  assign locked    = (state == ST_LOCKED);

  // NOTE: history is deliberately left out of reset; the PRIME word always
  // loads it before any prediction reads it.
  always_ff @(posedge clk) begin
    if (din_valid) history <= din[ORDER-1:0];
  end

  // Lock FSM and per-word result.
  always_comb begin
    state_nx    = state;
    run_ok_nx   = run_ok;
    run_bad_nx  = run_bad;
    error_nx    = error;
    err_bits_nx = err_bits;
    if (din_valid) begin
      case (state)
        ST_PRIME: begin
          state_nx    = ST_HUNT;
          run_ok_nx   = '0;
          run_bad_nx  = '0;
          error_nx    = 1'b0;
          err_bits_nx = '0;
        end
        ST_HUNT: begin
          error_nx    = word_err;
          err_bits_nx = word_bits;
          run_bad_nx  = '0;
          if (word_err) begin
            run_ok_nx = '0;
          end else if (int'(run_ok) + 1 >= LOCK_CNT) begin
            run_ok_nx = RUNW'(LOCK_CNT);
            state_nx  = ST_LOCKED;
          end else begin
            run_ok_nx = run_ok + 1'b1;
          end
        end
        ST_LOCKED: begin
          error_nx    = word_err;
          err_bits_nx = word_bits;
          if (!word_err) begin
            run_bad_nx = '0;
          end else if (int'(run_bad) + 1 >= UNLOCK_CNT) begin
            state_nx   = ST_HUNT;
            run_ok_nx  = '0;
            run_bad_nx = '0;
          end else begin
            run_bad_nx = run_bad + 1'b1;
          end
        end
        default: state_nx = ST_PRIME;
      endcase
    end
  end

  // Saturating accumulator; only words checked while already LOCKED count.
  always_comb begin
    cnt_sum    = SUMW'(err_cnt) + SUMW'(word_bits);
    err_cnt_nx = err_cnt;
    if (clr_cnt)
      err_cnt_nx = '0;
    else if (din_valid && state == ST_LOCKED)
      err_cnt_nx = (cnt_sum > SUMW'({CNT_WIDTH{1'b1}})) ? '1
                                                         : cnt_sum[CNT_WIDTH-1:0];
  end

  // NOTE: registers are updated with non-blocking assignments so every
  // block sees the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_PRIME;
      run_ok   <= '0;
      run_bad  <= '0;
      error    <= 1'b0;
      err_bits <= '0;
      err_cnt  <= '0;
    end else begin
      state    <= state_nx;
      run_ok   <= run_ok_nx;
      run_bad  <= run_bad_nx;
      error    <= error_nx;
      err_bits <= err_bits_nx;
      err_cnt  <= err_cnt_nx;
    end
  end

endmodule

// File: tb/tb_prbs_sync_checker.sv
// ----------------------------------------------------------------------------
// tb_prbs_sync_checker
// Three checker instances (40b/PRBS7/16b count, 40b/PRBS7/4b count,
// 32b/PRBS31/16b count), exercised one at a time against a bit-stream
// reference model that applies the recurrence directly on a queue of line
// bits and tracks lock with plain run counters.
// ----------------------------------------------------------------------------
module tb_prbs_sync_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        clr_cnt;
  logic [39:0] din;
  logic        va, vb, vc;

  logic        a_error, b_error, c_error;
  logic [5:0]  a_bits, b_bits, c_bits;
  logic        a_locked, b_locked, c_locked;
  logic [15:0] a_cnt, c_cnt;
  logic [3:0]  b_cnt;

  prbs_sync_checker #(.WORDWIDTH(40), .ORDER(7), .LOCK_CNT(4), .UNLOCK_CNT(4), .CNT_WIDTH(16)) u_a (
    .clk(clk), .reset(reset), .din(din), .din_valid(va), .clr_cnt(clr_cnt),
    .error(a_error), .err_bits(a_bits), .locked(a_locked), .err_cnt(a_cnt));

  prbs_sync_checker #(.WORDWIDTH(40), .ORDER(7), .LOCK_CNT(4), .UNLOCK_CNT(4), .CNT_WIDTH(4)) u_b (
    .clk(clk), .reset(reset), .din(din), .din_valid(vb), .clr_cnt(clr_cnt),
    .error(b_error), .err_bits(b_bits), .locked(b_locked), .err_cnt(b_cnt));

  prbs_sync_checker #(.WORDWIDTH(32), .ORDER(31), .LOCK_CNT(4), .UNLOCK_CNT(4), .CNT_WIDTH(16)) u_c (
    .clk(clk), .reset(reset), .din(din[31:0]), .din_valid(vc), .clr_cnt(clr_cnt),
    .error(c_error), .err_bits(c_bits), .locked(c_locked), .err_cnt(c_cnt));

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int     sel;
  int     m_ww, m_order, m_a, m_b;
  longint m_cntmax;
  bit     m_hist[$];
  bit     m_primed, m_locked;
  int     m_ok, m_bad;
  bit     e_error;
  int     e_bits;
  longint e_cnt;

  function automatic int short_tap(input int order);
    case (order)
      7:  return 6;
      9:  return 5;
      15: return 14;
      23: return 18;
      default: return 28;
    endcase
  endfunction

  task automatic set_cfg(input int s, input int ww, input int order, input int cw);
    sel      = s;
    m_ww     = ww;
    m_order  = order;
    m_a      = order;
    m_b      = short_tap(order);
    m_cntmax = (longint'(1) << cw) - 1;
  endtask

  task automatic model_reset();
    m_hist.delete();
    m_primed = 0;
    m_locked = 0;
    m_ok     = 0;
    m_bad    = 0;
    e_error  = 0;
    e_bits   = 0;
    e_cnt    = 0;
  endtask

  task automatic model_word(input logic [39:0] w);
    bit win[$];
    int mism;
    bit allz;
    win = m_hist;
    for (int j = 0; j < m_ww; j++) win.push_back(w[m_ww-1-j]);
    if (m_primed) begin
      mism = 0;
      for (int n = m_order; n < win.size(); n++)
        if (win[n] != (win[n-m_a] ^ win[n-m_b])) mism++;
      allz = 1;
      foreach (win[i]) if (win[i]) allz = 0;
      e_bits  = allz ? m_ww : mism;
      e_error = (e_bits != 0);
      if (m_locked) begin
        e_cnt = (e_cnt + e_bits > m_cntmax) ? m_cntmax : e_cnt + e_bits;
        if (e_error) begin
          m_bad++;
          if (m_bad == 4) begin
            m_locked = 0;
            m_ok     = 0;
            m_bad    = 0;
          end
        end else begin
          m_bad = 0;
        end
      end else if (e_error) begin
        m_ok = 0;
      end else begin
        m_ok++;
        if (m_ok == 4) m_locked = 1;
      end
    end else begin
      m_primed = 1;
      e_error  = 0;
      e_bits   = 0;
    end
    m_hist.delete();
    for (int i = win.size() - m_order; i < win.size(); i++) m_hist.push_back(win[i]);
  endtask

  // ---------------- PRBS source ----------------
  bit g_q[$];

  task automatic gen_seed(input logic [30:0] seed);
    g_q.delete();
    for (int i = m_order - 1; i >= 0; i--) g_q.push_back(seed[i]);
  endtask

  task automatic gen_word(output logic [39:0] w);
    bit nb;
    w = '0;
    for (int j = 0; j < m_ww; j++) begin
      nb = g_q[g_q.size()-m_a] ^ g_q[g_q.size()-m_b];
      g_q.push_back(nb);
      if (g_q.size() > 31) void'(g_q.pop_front());
      w[m_ww-1-j] = nb;
    end
  endtask

  // ---------------- drive / compare ----------------
  task automatic compare();
    case (sel)
      0: begin
        check("a.error", a_error, e_error);
        check("a.err_bits", a_bits, e_bits);
        check("a.locked", a_locked, m_locked);
        check("a.err_cnt", a_cnt, e_cnt);
      end
      1: begin
        check("b.error", b_error, e_error);
        check("b.err_bits", b_bits, e_bits);
        check("b.locked", b_locked, m_locked);
        check("b.err_cnt", b_cnt, e_cnt);
      end
      default: begin
        check("c.error", c_error, e_error);
        check("c.err_bits", c_bits, e_bits);
        check("c.locked", c_locked, m_locked);
        check("c.err_cnt", c_cnt, e_cnt);
      end
    endcase
  endtask

  task automatic cycle(input bit v, input logic [39:0] w, input bit clr, input bit rst);
    @(negedge clk);
    reset   = rst;
    clr_cnt = clr;
    din     = w;
    va      = v && (sel == 0);
    vb      = v && (sel == 1);
    vc      = v && (sel == 2);
    if (rst) begin
      model_reset();
    end else begin
      if (v)   model_word(w);
      if (clr) e_cnt = 0;
    end
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic send_clean();
    logic [39:0] w;
    gen_word(w);
    cycle(1'b1, w, 1'b0, 1'b0);
  endtask

  // pos counts from the earliest bit of the word on the line.
  task automatic send_flip(input int pos, input bit clr);
    logic [39:0] w;
    gen_word(w);
    w[m_ww-1-pos] = ~w[m_ww-1-pos];
    cycle(1'b1, w, clr, 1'b0);
  endtask

  initial begin
    logic [39:0] w;
    logic [30:0] seed;
    int kind;
    bit v;

    reset = 1'b1; clr_cnt = 1'b0; din = '0; va = 1'b0; vb = 1'b0; vc = 1'b0;

    // ---- instance A: 40b, PRBS7, 16b count ----
    set_cfg(0, 40, 7, 16);
    model_reset();
    cycle(1'b0, '0, 1'b0, 1'b1);
    gen_seed(31'h7F);
    repeat (5) send_clean();
    check("a.lock_on_word5", a_locked, 1);
    repeat (3) send_clean();

    send_flip(20, 1'b0);
    check("a.flip20_bits", a_bits, 3);
    check("a.flip20_cnt", a_cnt, 3);
    repeat (2) send_clean();
    send_flip(38, 1'b0);
    check("a.flip38_head", a_bits, 1);
    send_clean();
    check("a.flip38_tail", a_bits, 2);
    check("a.flip38_cnt", a_cnt, 6);
    send_clean();

    // clear, then a run of stuck-at-zero words drops lock on the 4th
    gen_word(w);
    cycle(1'b1, w, 1'b1, 1'b0);
    repeat (4) cycle(1'b1, '0, 1'b0, 1'b0);
    check("a.unlock_4th_zero", a_locked, 0);
    repeat (6) send_clean();

    // build err_cnt = 9 while locked, then reset (beats clr and din_valid)
    gen_word(w);
    cycle(1'b1, w, 1'b1, 1'b0);
    repeat (3) begin
      send_flip($urandom_range(0, 32), 1'b0);
      repeat (2) send_clean();
    end
    check("a.cnt_before_reset", a_cnt, 9);
    gen_word(w);
    cycle(1'b1, w, 1'b1, 1'b1);
    repeat (5) send_clean();
    check("a.relock_after_reset", a_locked, 1);

    // randomized soak: flips, stuck words, gaps, occasional clears
    repeat (300) begin
      v    = ($urandom_range(0, 3) != 0);
      kind = $urandom_range(0, 19);
      if (!v) begin
        cycle(1'b0, {$urandom, $urandom}, 1'b0, 1'b0);
      end else if (kind == 1) begin
        repeat ($urandom_range(1, 5)) cycle(1'b1, '0, 1'b0, 1'b0);
      end else begin
        gen_word(w);
        if (kind == 0) w[$urandom_range(0, 39)] ^= 1'b1;
        if (kind == 2) w ^= 40'(1) << $urandom_range(0, 39);
        cycle(1'b1, w, ($urandom_range(0, 29) == 0), 1'b0);
      end
    end

    // ---- instance B: 4b saturating count ----
    set_cfg(1, 40, 7, 4);
    cycle(1'b0, '0, 1'b0, 1'b1);
    gen_seed(31'($urandom_range(1, 127)));
    repeat (6) send_clean();
    for (int i = 0; i < 6; i++) begin
      send_flip($urandom_range(0, 32), 1'b0);
      repeat (2) send_clean();
    end
    check("b.saturated", b_cnt, 15);
    send_flip($urandom_range(0, 32), 1'b1);
    check("b.clr_with_error", b_cnt, 0);
    repeat (3) send_clean();

    // ---- instance C: 32b, PRBS31, gapped valid ----
    set_cfg(2, 32, 31, 16);
    cycle(1'b0, '0, 1'b0, 1'b1);
    seed = 31'($urandom) | 31'd1;
    gen_seed(seed);
    for (int i = 0; i < 12; i++) begin
      send_clean();
      if (i == 4) check("c.lock_after_5", c_locked, 1);
      cycle(1'b0, {8'h0, $urandom}, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
